// File: rtl/pipe_align_pkg.sv
// Shared constants and types for the PIPE RX symbol-phase aligner.
package pipe_align_pkg;

   localparam logic [7:0] COM_SYM = 8'hBC;

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2
   } align_state_e;

   // Width of a lane index for n lanes (at least 1 bit).
   function automatic int unsigned lane_idx_width(input int unsigned n);
      int unsigned w;
      w = 1;
      for (int unsigned i = 1; i < 8; i++) begin
         if ((32'd1 << i) < n) w = i + 1;
      end
      return w;
   endfunction

endpackage

// File: rtl/pipe_com_detect.sv
// Combinational COM (K28.5) finder over the byte lanes of one PIPE RX word.
module pipe_com_detect
   import pipe_align_pkg::*;
#(
   parameter int unsigned Lanes = 4,
   parameter int unsigned IdxW  = 2
) (
   input  logic [8*Lanes-1:0] data,
   input  logic [Lanes-1:0]   datak,
   input  logic [IdxW-1:0]    sel_lane,
   output logic               any_com_c,
   output logic [IdxW-1:0]    low_lane_c,
   output logic               com_at_sel_c
);

   logic [Lanes-1:0] com_vec;

   // Per-lane COM flag: K symbol whose byte is K28.5.
   always_comb begin
      com_vec = '0;
      for (int i = 0; i < int'(Lanes); i++) begin
         com_vec[i] = datak[i] && (data[8*i +: 8] == COM_SYM);
      end
   end

   assign any_com_c = |com_vec;

   // Lowest-lane priority encode; descending scan so lane 0 wins.
   always_comb begin
      low_lane_c = '0;
      for (int i = int'(Lanes) - 1; i >= 0; i--) begin
         if (com_vec[i]) low_lane_c = IdxW'(i);
      end
   end

   // COM present in the selected lane.
   always_comb begin
      com_at_sel_c = 1'b0;
      for (int i = 0; i < int'(Lanes); i++) begin
         if (sel_lane == IdxW'(i)) com_at_sel_c = com_vec[i];
      end
   end

endmodule

// File: rtl/pipe_rx_symbol_align.sv
// PIPE RX symbol-phase aligner: finds the COM lane, qualifies lock and
// rotates the RX word so lane 0 always starts on a COM-aligned boundary.
module pipe_rx_symbol_align
   import pipe_align_pkg::*;
#(
   parameter int unsigned DataWidth   = 32,
   parameter int unsigned LockCount   = 4,
   parameter int unsigned UnlockCount = 3
) (
   input  logic                   pcieclk,
   input  logic                   nreset,
   input  logic [DataWidth-1:0]   rx_data,
   input  logic [DataWidth/8-1:0] rx_datak,
   input  logic                   rx_word_vld,
   input  logic                   force_realign,
   output logic [DataWidth-1:0]   aligned_data,
   output logic [DataWidth/8-1:0] aligned_datak,
   output logic                   aligned_vld,
   output logic [2:0]             align_offset,
   output logic                   locked,
   output logic                   align_err
);

   localparam int unsigned Lanes = DataWidth / 8;
   localparam int unsigned IdxW  = lane_idx_width(Lanes);
   localparam int unsigned CntW  = 4;
   localparam logic [CntW-1:0] CntMax    = '1;
   localparam logic [CntW-1:0] LockCnt   = CntW'(LockCount);
   localparam logic [CntW-1:0] UnlockCnt = CntW'(UnlockCount);

   align_state_e     state_q, state_d;
   logic [IdxW-1:0]  offset_q, offset_d;
   logic [CntW-1:0]  match_q, match_d, match_inc;
   logic [CntW-1:0]  err_q, err_d, err_inc;
   logic             align_err_d;

   logic             any_com;
   logic [IdxW-1:0]  low_lane;
   logic             com_at_off;

   logic [DataWidth-1:0]   prev_data_q;
   logic [Lanes-1:0]       prev_datak_q;
   logic [2*DataWidth-1:0] cat_data;
   logic [2*Lanes-1:0]     cat_datak;
   logic [DataWidth-1:0]   rot_data;
   logic [Lanes-1:0]       rot_datak;

   pipe_com_detect #(
      .Lanes (Lanes),
      .IdxW  (IdxW)
   ) u_com_detect (
      .data         (rx_data),
      .datak        (rx_datak),
      .sel_lane     (offset_q),
      .any_com_c    (any_com),
      .low_lane_c   (low_lane),
      .com_at_sel_c (com_at_off)
   );

   // Saturating increments for the 4-bit counters.
   assign match_inc = (match_q == CntMax) ? match_q : match_q + CntW'(1);
   assign err_inc   = (err_q   == CntMax) ? err_q   : err_q   + CntW'(1);

   // Output lane j comes from lane offset+j of {current, previous}.
   assign cat_data  = {rx_data, prev_data_q};
   assign cat_datak = {rx_datak, prev_datak_q};
   assign rot_data  = DataWidth'(cat_data >> {offset_q, 3'b000});
   assign rot_datak = Lanes'(cat_datak >> offset_q);

   assign align_offset = 3'(offset_q);

   // Lock FSM next-state, offset and counter update; realign request wins.
   always_comb begin
      state_d     = state_q;
      offset_d    = offset_q;
      match_d     = match_q;
      err_d       = err_q;
      align_err_d = 1'b0;
      if (force_realign) begin
         state_d = SEARCH;
         match_d = '0;
         err_d   = '0;
      end else if (rx_word_vld) begin
         case (state_q)
            SEARCH: begin
               if (any_com) begin
                  offset_d = low_lane;
                  match_d  = CntW'(1);
                  state_d  = (LockCnt <= CntW'(1)) ? LOCKED : CHECK;
               end
            end
            CHECK: begin
               if (com_at_off) begin
                  match_d = match_inc;
                  if (match_inc >= LockCnt) state_d = LOCKED;
               end else if (any_com) begin
                  offset_d = low_lane;
                  match_d  = CntW'(1);
               end
            end
            LOCKED: begin
               if (com_at_off) begin
                  err_d = '0;
               end else if (any_com) begin
                  align_err_d = 1'b1;
                  err_d       = err_inc;
                  if (err_inc >= UnlockCnt) begin
                     state_d = SEARCH;
                     err_d   = '0;
                     match_d = '0;
                  end
               end
            end
            default: state_d = SEARCH;
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge pcieclk or negedge nreset) begin
      if (!nreset) begin
         state_q   <= SEARCH;
         offset_q  <= '0;
         match_q   <= '0;
         err_q     <= '0;
         locked    <= 1'b0;
         align_err <= 1'b0;
      end else begin
         state_q   <= state_d;
         offset_q  <= offset_d;
         match_q   <= match_d;
         err_q     <= err_d;
         locked    <= (state_d == LOCKED);
         align_err <= align_err_d;
      end
   end

   // Datapath: previous-word store and registered rotated output.
   always_ff @(posedge pcieclk or negedge nreset) begin
      if (!nreset) begin
         prev_data_q   <= '0;
         prev_datak_q  <= '0;
         aligned_data  <= '0;
         aligned_datak <= '0;
         aligned_vld   <= 1'b0;
      end else begin
         aligned_vld <= rx_word_vld;
         if (rx_word_vld) begin
            aligned_data  <= rot_data;
            aligned_datak <= rot_datak;
            prev_data_q   <= rx_data;
            prev_datak_q  <= rx_datak;
         end
      end
   end

endmodule

// File: tb/tb_pipe_rx_symbol_align.sv
// Directed bench for pipe_rx_symbol_align at 32-, 64- and 8-bit widths.
module tb_pipe_rx_symbol_align;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic nreset;

   logic [31:0] d32, ad32;
   logic [3:0]  k32, ak32;
   logic        v32, f32, av32, lk32, er32;
   logic [2:0]  off32;

   logic [63:0] d64, ad64;
   logic [7:0]  k64, ak64;
   logic        v64, f64, av64, lk64, er64;
   logic [2:0]  off64;

   logic [7:0]  d8, ad8;
   logic [0:0]  k8, ak8;
   logic        v8, f8, av8, lk8, er8;
   logic [2:0]  off8;

   int unsigned vectors     = 0;
   int unsigned miscompares = 0;

   pipe_rx_symbol_align #(.DataWidth(32), .LockCount(4), .UnlockCount(3)) u_dut32 (
      .pcieclk(clk), .nreset(nreset), .rx_data(d32), .rx_datak(k32),
      .rx_word_vld(v32), .force_realign(f32), .aligned_data(ad32),
      .aligned_datak(ak32), .aligned_vld(av32), .align_offset(off32),
      .locked(lk32), .align_err(er32));

   pipe_rx_symbol_align #(.DataWidth(64), .LockCount(4), .UnlockCount(3)) u_dut64 (
      .pcieclk(clk), .nreset(nreset), .rx_data(d64), .rx_datak(k64),
      .rx_word_vld(v64), .force_realign(f64), .aligned_data(ad64),
      .aligned_datak(ak64), .aligned_vld(av64), .align_offset(off64),
      .locked(lk64), .align_err(er64));

   pipe_rx_symbol_align #(.DataWidth(8), .LockCount(4), .UnlockCount(3)) u_dut8 (
      .pcieclk(clk), .nreset(nreset), .rx_data(d8), .rx_datak(k8),
      .rx_word_vld(v8), .force_realign(f8), .aligned_data(ad8),
      .aligned_datak(ak8), .aligned_vld(av8), .align_offset(off8),
      .locked(lk8), .align_err(er8));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Word with COM at lanes c0/c1 (-1 = none), other lanes seed+lane.
   function automatic logic [63:0] mkd(input int lanes, input int c0, input int c1,
                                       input logic [7:0] seed);
      logic [63:0] d;
      d = '0;
      for (int i = 0; i < lanes; i++)
         d[8*i +: 8] = (i == c0 || i == c1) ? 8'hBC : seed + 8'(i);
      return d;
   endfunction

   function automatic logic [7:0] mkk(input int c0, input int c1);
      logic [7:0] k;
      k = '0;
      if (c0 >= 0) k[3'(c0)] = 1'b1;
      if (c1 >= 0) k[3'(c1)] = 1'b1;
      return k;
   endfunction

   task automatic w32(input int c0, input logic [7:0] seed, input logic frc = 1'b0);
      repeat (3) @(negedge clk);
      d32 = 32'(mkd(4, c0, -1, seed));
      k32 = 4'(mkk(c0, -1));
      v32 = 1'b1;
      f32 = frc;
      @(negedge clk);
      v32 = 1'b0;
      f32 = 1'b0;
   endtask

   task automatic w64(input int c0, input int c1, input logic [7:0] seed);
      repeat (7) @(negedge clk);
      d64 = mkd(8, c0, c1, seed);
      k64 = mkk(c0, c1);
      v64 = 1'b1;
      @(negedge clk);
      v64 = 1'b0;
   endtask

   task automatic w8(input logic [7:0] b, input logic k);
      d8 = b;
      k8 = k;
      v8 = 1'b1;
      @(negedge clk);
      v8 = 1'b0;
   endtask

   initial begin
      nreset = 1'b0;
      d32 = '0; k32 = '0; v32 = 1'b0; f32 = 1'b0;
      d64 = '0; k64 = '0; v64 = 1'b0; f64 = 1'b0;
      d8  = '0; k8  = '0; v8  = 1'b0; f8  = 1'b0;
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      @(negedge clk);

      // Reset state
      chk("rst_data32", 64'(ad32), 64'h0);
      chk("rst_vld32", 64'(av32), 64'h0);
      chk("rst_off32", 64'(off32), 64'h0);
      chk("rst_lock32", 64'(lk32), 64'h0);
      chk("rst_err32", 64'(er32), 64'h0);
      chk("rst_lock64", 64'(lk64), 64'h0);

      // Alignment to lane 2
      w32(2, 8'h10);
      chk("a1_off", 64'(off32), 64'd2);
      chk("a1_lock", 64'(lk32), 64'h0);
      chk("a1_vld", 64'(av32), 64'h1);
      chk("a1_data", 64'(ad32), 64'h0);
      @(negedge clk);
      chk("a1_vld_drop", 64'(av32), 64'h0);
      w32(2, 8'h20);
      chk("a2_data", 64'(ad32), 64'h212013BC);
      chk("a2_k", 64'(ak32), 64'h1);
      chk("a2_lock", 64'(lk32), 64'h0);
      w32(2, 8'h30);
      chk("a3_lock", 64'(lk32), 64'h0);
      w32(2, 8'h40);
      chk("a4_lock", 64'(lk32), 64'h1);
      chk("a4_off", 64'(off32), 64'd2);
      w32(2, 8'h50);
      chk("a5_data", 64'(ad32), 64'h515043BC);
      chk("a5_k", 64'(ak32), 64'h1);
      chk("a5_err", 64'(er32), 64'h0);

      // force_realign with a good COM word in LOCKED
      w32(2, 8'h60, 1'b1);
      chk("fr_lock", 64'(lk32), 64'h0);
      chk("fr_vld", 64'(av32), 64'h1);
      chk("fr_off", 64'(off32), 64'd2);
      chk("fr_data", 64'(ad32), 64'h616053BC);

      // Lane change during CHECK
      w32(1, 8'h70);
      chk("lc1_off", 64'(off32), 64'd1);
      w32(1, 8'h80);
      chk("lc2_lock", 64'(lk32), 64'h0);
      w32(3, 8'h90);
      chk("lc3_off", 64'(off32), 64'd3);
      chk("lc3_lock", 64'(lk32), 64'h0);
      w32(3, 8'hA0);
      w32(3, 8'hB0);
      chk("lc5_lock", 64'(lk32), 64'h0);
      w32(3, 8'hC0);
      chk("lc6_lock", 64'(lk32), 64'h1);
      w32(3, 8'hD0);
      chk("lc7_data", 64'(ad32), 64'hD2D1D0BC);
      chk("lc7_err", 64'(er32), 64'h0);

      // Standalone force_realign, then lock at offset 0
      f32 = 1'b1;
      @(negedge clk);
      f32 = 1'b0;
      chk("fr2_lock", 64'(lk32), 64'h0);
      chk("fr2_off", 64'(off32), 64'd3);
      w32(0, 8'h10);
      chk("l0_off", 64'(off32), 64'd0);
      w32(0, 8'h11);
      w32(0, 8'h12);
      w32(0, 8'h13);
      chk("l0_lock", 64'(lk32), 64'h1);

      // Lock loss after three misplaced COMs
      w32(2, 8'h20);
      chk("ll1_err", 64'(er32), 64'h1);
      chk("ll1_lock", 64'(lk32), 64'h1);
      @(negedge clk);
      chk("ll1_err_pulse", 64'(er32), 64'h0);
      w32(2, 8'h30);
      chk("ll2_err", 64'(er32), 64'h1);
      chk("ll2_lock", 64'(lk32), 64'h1);
      w32(2, 8'h40);
      chk("ll3_err", 64'(er32), 64'h1);
      chk("ll3_lock", 64'(lk32), 64'h0);
      chk("ll3_off", 64'(off32), 64'd0);

      // Good COM between bad ones keeps lock
      w32(0, 8'h50); w32(0, 8'h51); w32(0, 8'h52); w32(0, 8'h53);
      chk("rl_lock", 64'(lk32), 64'h1);
      w32(2, 8'h60);
      chk("gb1_err", 64'(er32), 64'h1);
      w32(2, 8'h61);
      chk("gb2_err", 64'(er32), 64'h1);
      w32(0, 8'h62);
      chk("gb_good_err", 64'(er32), 64'h0);
      w32(2, 8'h63);
      chk("gb3_err", 64'(er32), 64'h1);
      chk("gb3_lock", 64'(lk32), 64'h1);
      w32(2, 8'h64);
      chk("gb4_lock", 64'(lk32), 64'h1);

      // 64-bit: dual COM while LOCKED at offset 0
      w64(0, -1, 8'h10); w64(0, -1, 8'h20); w64(0, -1, 8'h30);
      chk("d3_lock", 64'(lk64), 64'h0);
      w64(0, -1, 8'h40);
      chk("d4_lock", 64'(lk64), 64'h1);
      w64(4, -1, 8'h50);
      chk("d5_err", 64'(er64), 64'h1);
      w64(0, 4, 8'h60);
      chk("dual_err", 64'(er64), 64'h0);
      chk("dual_lock", 64'(lk64), 64'h1);
      chk("dual_data", ad64, 64'h575655BC53525150);
      chk("dual_k", 64'(ak64), 64'h10);
      w64(4, -1, 8'h70);
      chk("d7_err", 64'(er64), 64'h1);
      w64(4, -1, 8'h80);
      chk("d8_lock", 64'(lk64), 64'h1);
      w64(4, -1, 8'h90);
      chk("d9_lock", 64'(lk64), 64'h0);
      chk("d9_off", 64'(off64), 64'd0);

      // 8-bit: one-word delay, lock, async reset mid-stream
      w8(8'h11, 1'b0);
      chk("b1_data", 64'(ad8), 64'h0);
      chk("b1_off", 64'(off8), 64'h0);
      w8(8'h22, 1'b0);
      chk("b2_data", 64'(ad8), 64'h11);
      chk("b2_k", 64'(ak8), 64'h0);
      w8(8'hBC, 1'b1);
      chk("b3_data", 64'(ad8), 64'h22);
      w8(8'hBC, 1'b1);
      chk("b4_data", 64'(ad8), 64'hBC);
      chk("b4_k", 64'(ak8), 64'h1);
      w8(8'hBC, 1'b1);
      chk("b5_lock", 64'(lk8), 64'h0);
      w8(8'hBC, 1'b1);
      chk("b6_lock", 64'(lk8), 64'h1);
      chk("b6_off", 64'(off8), 64'h0);
      w8(8'h33, 1'b0);
      chk("b7_data", 64'(ad8), 64'hBC);
      d8 = 8'h44; k8 = 1'b0; v8 = 1'b1;
      #2 nreset = 1'b0;
      #1;
      chk("ar_data8", 64'(ad8), 64'h0);
      chk("ar_k8", 64'(ak8), 64'h0);
      chk("ar_vld8", 64'(av8), 64'h0);
      chk("ar_lock8", 64'(lk8), 64'h0);
      chk("ar_err8", 64'(er8), 64'h0);
      chk("ar_lock32", 64'(lk32), 64'h0);
      @(negedge clk);
      v8 = 1'b0;
      nreset = 1'b1;
      w8(8'h55, 1'b0);
      chk("ar_first", 64'(ad8), 64'h0);
      w8(8'h66, 1'b0);
      chk("ar_second", 64'(ad8), 64'h55);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
